// File: rtl/dnf_sweep_checker.sv
// ============================================================================
// Module      : dnf_sweep_checker
// Description : Exhaustive equivalence sweep of two W-input combinational
//               function blocks with mismatch statistics and first-fail capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dnf_sweep_checker #(
    parameter int W          = 5,
    parameter int SETTLE_CYC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    output logic [W-1:0] vec_o,
    input  logic         f_a,
    input  logic         f_b,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [W:0]   err_cnt,
    output logic         first_err_valid,
    output logic [W-1:0] first_err_vec,
    output logic [W:0]   ones_a,
    output logic [W:0]   ones_b
);

    localparam int                WAIT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(SETTLE_CYC - 1);
    localparam logic [W-1:0]      VEC_LAST    = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mismatch;
    logic [W:0]        err_cnt_next;

    assign mismatch     = f_a ^ f_b;
    // Verdict at the last vector must include that vector's own compare.
    assign err_cnt_next = err_cnt + (W+1)'(mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            vec_o           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            ones_a          <= '0;
            ones_b          <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, FINISH: begin
                    if (start && !abort) begin
                        vec_o           <= '0;
                        err_cnt         <= '0;
                        ones_a          <= '0;
                        ones_b          <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                        pass            <= 1'b0;
                        busy            <= 1'b1;
                        wait_cnt        <= WAIT_RELOAD;
                        state           <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (wait_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                    end else begin
                        ones_a  <= ones_a + (W+1)'(f_a);
                        ones_b  <= ones_b + (W+1)'(f_b);
                        err_cnt <= err_cnt_next;
                        if (mismatch && !first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= vec_o;
                        end
                        if (vec_o == VEC_LAST) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_cnt_next == '0);
                        end else begin
                            vec_o    <= vec_o + 1'b1;
                            wait_cnt <= WAIT_RELOAD;
                            state    <= SETTLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dnf_sweep_checker.sv
// ============================================================================
// Module      : tb_dnf_sweep_checker
// Description : Scoreboard bench for dnf_sweep_checker (SETTLE_CYC=1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dnf_sweep_checker;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, abort = 1'b0, start3 = 1'b0, abort3 = 1'b0;
    logic [W-1:0] vec_o, vec3;
    logic         f_a, f_b, f_a3, f_b3;
    logic         busy, done, pass, busy3, done3, pass3;
    logic [W:0]   err_cnt, ones_a, ones_b, err3, oa3, ob3;
    logic         fev, fev3;
    logic [W-1:0] fvec, fvec3;

    int mode  = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W:0]   err;
        logic [W:0]   oa;
        logic [W:0]   ob;
        logic         fv;
        logic [W-1:0] fvec;
        logic         pass;
        int           lat;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    // Function blocks under test: A is the reference form, B has planted faults per mode.
    function automatic logic ref_a(input logic [W-1:0] v, input int m);
        if (m == 3) return ^v;
        return v[0];
    endfunction

    function automatic logic ref_b(input logic [W-1:0] v, input int m);
        case (m)
            1:       return ref_a(v, m) ^ (v == 5'd9);
            2:       return ~ref_a(v, m);
            3:       return ref_a(v, m) ^ (v == 5'd31);
            default: return ref_a(v, m);
        endcase
    endfunction

    assign f_a  = ref_a(vec_o, mode);
    assign f_b  = ref_b(vec_o, mode);
    assign f_a3 = ref_a(vec3, mode);
    assign f_b3 = ref_b(vec3, mode);

    dnf_sweep_checker #(.W(W), .SETTLE_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_o(vec_o),
        .f_a(f_a), .f_b(f_b), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_valid(fev), .first_err_vec(fvec),
        .ones_a(ones_a), .ones_b(ones_b)
    );

    dnf_sweep_checker #(.W(W), .SETTLE_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .vec_o(vec3),
        .f_a(f_a3), .f_b(f_b3), .busy(busy3), .done(done3), .pass(pass3),
        .err_cnt(err3), .first_err_valid(fev3), .first_err_vec(fvec3),
        .ones_a(oa3), .ones_b(ob3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input int period);
        exp_t e;
        e.err = '0; e.oa = '0; e.ob = '0; e.fv = 1'b0; e.fvec = '0;
        for (int v = 0; v < (1 << W); v++) begin
            logic a, b;
            a = ref_a(W'(v), mode);
            b = ref_b(W'(v), mode);
            e.oa = e.oa + (W+1)'(a);
            e.ob = e.ob + (W+1)'(b);
            if (a != b) begin
                e.err = e.err + 1'b1;
                if (!e.fv) begin
                    e.fv   = 1'b1;
                    e.fvec = W'(v);
                end
            end
        end
        e.pass = (e.err == 0);
        e.lat  = (1 << W) * period;
        sbq.push_back(e);
    endtask

    // One full sweep on dut (sel=0) or dut3 (sel=1); extra_start_at re-pulses start mid-sweep.
    task automatic run_sweep(input int sel, input int extra_start_at, input string name);
        int period, lat, vbad, bbad, ev;
        bit got;
        logic [W-1:0] v;
        logic b, d, cfv, cps;
        logic [W:0] cerr, coa, cob;
        logic [W-1:0] cfvec;
        exp_t e;
        period = (sel == 0) ? 2 : 4;
        lat = 0; vbad = 0; bbad = 0; got = 0;
        cfv = 0; cps = 0; cerr = '0; coa = '0; cob = '0; cfvec = '0;
        push_expected(period);
        if (sel == 0) start = 1'b1; else start3 = 1'b1;
        tick();
        start = 1'b0; start3 = 1'b0;
        for (int c = 1; c <= (1 << W) * period + 20 && !got; c++) begin
            if (c == extra_start_at) begin
                if (sel == 0) start = 1'b1; else start3 = 1'b1;
            end
            tick();
            start = 1'b0; start3 = 1'b0;
            v = (sel == 0) ? vec_o : vec3;
            b = (sel == 0) ? busy : busy3;
            d = (sel == 0) ? done : done3;
            ev = c / period;
            if (ev > (1 << W) - 1) ev = (1 << W) - 1;
            if (v !== ev[W-1:0]) vbad++;
            if (d) begin
                got = 1; lat = c;
                cerr  = (sel == 0) ? err_cnt : err3;
                coa   = (sel == 0) ? ones_a : oa3;
                cob   = (sel == 0) ? ones_b : ob3;
                cfv   = (sel == 0) ? fev : fev3;
                cfvec = (sel == 0) ? fvec : fvec3;
                cps   = (sel == 0) ? pass : pass3;
                if (b !== 1'b0) bbad++;
            end else if (b !== 1'b1) begin
                bbad++;
            end
        end
        e = sbq.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s done_timeout: got no done, required done at %0d", name, e.lat);
        end else begin
            total++;
            if (lat !== e.lat) begin bad++; $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat); end
            total++;
            if (cerr !== e.err) begin bad++; $display("FAIL %s err_cnt: got %0d required %0d", name, cerr, e.err); end
            total++;
            if (coa !== e.oa) begin bad++; $display("FAIL %s ones_a: got %0d required %0d", name, coa, e.oa); end
            total++;
            if (cob !== e.ob) begin bad++; $display("FAIL %s ones_b: got %0d required %0d", name, cob, e.ob); end
            total++;
            if (cfv !== e.fv) begin bad++; $display("FAIL %s first_err_valid: got %0b required %0b", name, cfv, e.fv); end
            total++;
            if (cfvec !== e.fvec) begin bad++; $display("FAIL %s first_err_vec: got %0d required %0d", name, cfvec, e.fvec); end
            total++;
            if (cps !== e.pass) begin bad++; $display("FAIL %s pass: got %0b required %0b", name, cps, e.pass); end
        end
        total++;
        if (vbad != 0) begin bad++; $display("FAIL %s vec_seq: got %0d bad cycles required 0", name, vbad); end
        total++;
        if (bbad != 0) begin bad++; $display("FAIL %s busy_seq: got %0d bad cycles required 0", name, bbad); end
        tick();
        d = (sel == 0) ? done : done3;
        total++;
        if (d !== 1'b0) begin bad++; $display("FAIL %s done_width: got done=%0b one cycle later required 0", name, d); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total++;
        if ({vec_o, busy, done, pass, err_cnt, fev, fvec, ones_a, ones_b} !== '0) begin
            bad++; $display("FAIL reset_state: got nonzero outputs vec=%0d busy=%0b pass=%0b required all 0", vec_o, busy, pass);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%0b/%0b required 0", busy, busy3); end
    endtask

    task automatic test_clean_sweep();
        mode = 0;
        run_sweep(0, 0, "clean");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (pass !== 1'b1 || ones_a !== 6'd16 || busy !== 1'b0) begin
            bad++; $display("FAIL finish_abort: got pass=%0b ones_a=%0d busy=%0b required 1/16/0", pass, ones_a, busy);
        end
    endtask

    task automatic test_single_err();
        mode = 1;
        run_sweep(0, 0, "single_err");
    endtask

    task automatic test_all_err();
        mode = 2;
        run_sweep(0, 0, "all_err");
    endtask

    task automatic test_last_vec();
        mode = 3;
        run_sweep(0, 0, "last_vec");
    endtask

    task automatic test_abort();
        bit saw;
        mode = 0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (19) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        total++;
        if (busy !== 1'b0 || pass !== 1'b0) begin bad++; $display("FAIL abort_busy: got busy=%0b pass=%0b required 0/0", busy, pass); end
        total++;
        if (ones_a !== 6'd4 || err_cnt !== 6'd0) begin
            bad++; $display("FAIL abort_partial: got ones_a=%0d err=%0d required 4/0", ones_a, err_cnt);
        end
        saw = 0;
        repeat (80) begin
            tick();
            if (done) saw = 1;
        end
        total++;
        if (saw || ones_a !== 6'd4) begin bad++; $display("FAIL abort_no_done: got done_seen=%0b ones_a=%0d required 0/4", saw, ones_a); end
        run_sweep(0, 0, "abort_restart");
    endtask

    task automatic test_async_reset();
        mode = 0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (30) tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({vec_o, busy, done, pass, err_cnt, fev, fvec, ones_a, ones_b} !== '0) begin
            bad++; $display("FAIL async_reset: got vec=%0d busy=%0b ones_a=%0d required all 0", vec_o, busy, ones_a);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        run_sweep(0, 0, "post_reset");
    endtask

    task automatic test_back_to_back();
        mode = 1;
        run_sweep(0, 0, "b2b_first");
        mode = 0;
        run_sweep(0, 0, "b2b_second");
    endtask

    task automatic test_start_busy();
        mode = 2;
        run_sweep(0, 10, "start_busy");
    endtask

    task automatic test_start_abort();
        mode = 0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (9) tick();
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL start_abort: got busy=%0b required 0", busy); end
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_start_abort: got busy=%0b required 0", busy); end
    endtask

    task automatic test_settle3();
        mode = 1;
        run_sweep(1, 0, "settle3");
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_single_err();
        test_all_err();
        test_last_vec();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_start_busy();
        test_start_abort();
        test_settle3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
